port_rmw_ctrl: RTL

- Sequencing controller in front of the port SFR latches (P0..P3). Two requesters share it: req0 is the CPU execute stage, req1 is the debug/ISP agent.
- Executes byte writes, bit writes and read-modify-write operations (ANL/ORL/XRL/CPL on a port latch) as one atomic sequence on the SFR bus.
- Drives the SFR write interface exactly as the port blocks consume it: data, address, write enable, bit-write enable and bit value.

---
 rtl/port_ctrl_pkg.sv | 42 ++++
 rtl/rmw_alu.sv | 36 +++
 rtl/port_rmw_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/port_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// port_ctrl_pkg
// Shared definitions for the port SFR read-modify-write controller.
//   - op_t     : operation codes presented by the requesters
//   - state_t  : sequencing states of the controller FSM
//   - RMW_OP_MASK / is_rmw / is_bit_op : op classification helpers
// Ops 0..3 address a whole byte; ops 4..7 address a single bit, so bit 2
// of the op code tells the two apart.
// ---------------------------------------------------------------------------
package port_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_MOV  = 3'd0,
        OP_ANL  = 3'd1,
        OP_ORL  = 3'd2,
        OP_XRL  = 3'd3,
        OP_SETB = 3'd4,
        OP_CLRB = 3'd5,
        OP_CPLB = 3'd6,
        OP_MOVB = 3'd7
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_MODIFY = 3'd3,
        ST_WRITE  = 3'd4
    } state_t;

    // One bit per op code; set where the op needs the current latch value.
    localparam logic [7:0] RMW_OP_MASK = 8'b0100_1110;

    function automatic logic is_rmw(input op_t op);
        return RMW_OP_MASK[op];
    endfunction

    function automatic logic is_bit_op(input op_t op);
        return op[2];
    endfunction

endpackage

// File: rtl/rmw_alu.sv
// ---------------------------------------------------------------------------
// rmw_alu
// Combinational modify step of a read-modify-write sequence.
// Ports:
//   op          in  3  operation code (op_t encoding)
//   rd_data     in  8  current latch value read back from the SFR bus
//   operand     in  8  byte operand of the request
//   bit_idx     in  3  bit position inside the byte for bit ops
//   result_byte out 8  new byte value for ANL/ORL/XRL (operand otherwise)
//   result_bit  out 1  new bit value for CPLB/SETB (0 otherwise)
// ---------------------------------------------------------------------------
module rmw_alu
    import port_ctrl_pkg::*;
(
    input  logic [2:0] op,
    input  logic [7:0] rd_data,
    input  logic [7:0] operand,
    input  logic [2:0] bit_idx,
    output logic [7:0] result_byte,
    output logic       result_bit
);

    always_comb begin
        result_byte = operand;
        result_bit  = 1'b0;
        case (op_t'(op))
            OP_ANL:  result_byte = rd_data & operand;
            OP_ORL:  result_byte = rd_data | operand;
            OP_XRL:  result_byte = rd_data ^ operand;
            OP_SETB: result_bit  = 1'b1;
            OP_CPLB: result_bit  = ~rd_data[bit_idx];
            default: ;
        endcase
    end

endmodule

// File: rtl/port_rmw_ctrl.sv
// ---------------------------------------------------------------------------
// port_rmw_ctrl
// Sequencer in front of the port SFR latches. Two requesters (req0 = CPU
// execute stage, req1 = debug/ISP agent) share it; each granted request is
// run as one atomic sequence: direct ops go straight to a write, RMW ops
// read the latch, modify it and write it back.
// Ports:
//   clock, reset            clock and asynchronous active-low reset
//   reqN/opN/addrN/dataN/bitN  request N and its operands (held until ackN)
//   ack0, ack1              one-cycle completion pulse, in the write cycle
//   sfr_rd_en/sfr_rd_addr   read strobe and address (READ state only)
//   sfr_rd_data             read data, valid RD_LATENCY cycles after strobe
//   sfr_addr/sfr_data/sfr_bit  write payload, held between writes
//   sfr_write_en            write strobe
//   sfr_write_bit_en        marks the write as a single-bit write
//   busy                    high whenever a sequence is in progress
// ---------------------------------------------------------------------------
module port_rmw_ctrl
    import port_ctrl_pkg::*;
#(
    parameter int RD_LATENCY = 1
)
(
    input  logic       clock,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic [2:0] op0,
    input  logic [2:0] op1,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic       bit0,
    input  logic       bit1,
    output logic       ack0,
    output logic       ack1,
    output logic       sfr_rd_en,
    output logic [7:0] sfr_rd_addr,
    input  logic [7:0] sfr_rd_data,
    output logic [7:0] sfr_addr,
    output logic [7:0] sfr_data,
    output logic       sfr_bit,
    output logic       sfr_write_en,
    output logic       sfr_write_bit_en,
    output logic       busy
);

    state_t     state_q, state_d;
    logic       last_grant_q;
    logic       grant_q;
    logic [2:0] op_q;
    logic [7:0] addr_q;
    logic [7:0] data_q;
    logic       bit_q;
    logic [7:0] sfr_addr_q;
    logic [7:0] sfr_data_q;
    logic       sfr_bit_q;

    logic       any_req;
    logic       grant_sel;
    logic [2:0] sel_op;
    logic [7:0] sel_addr;
    logic [7:0] sel_data;
    logic       sel_bit;
    logic [7:0] alu_byte;
    logic       alu_bit;

    // Round-robin only matters when both ask at once; otherwise the single
    // requester wins. A lone req1 gives 1, a lone req0 gives 0.
    assign any_req   = req0 | req1;
    assign grant_sel = (req0 & req1) ? ~last_grant_q : req1;
    assign sel_op    = grant_sel ? op1   : op0;
    assign sel_addr  = grant_sel ? addr1 : addr0;
    assign sel_data  = grant_sel ? data1 : data0;
    assign sel_bit   = grant_sel ? bit1  : bit0;

    rmw_alu u_alu (
        .op          (op_q),
        .rd_data     (sfr_rd_data),
        .operand     (data_q),
        .bit_idx     (addr_q[2:0]),
        .result_byte (alu_byte),
        .result_bit  (alu_bit)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and the strobes. Strobes and acks are decoded from
    // the current state so an asynchronous reset kills them at once.
    always_comb begin
        state_d          = state_q;
        sfr_rd_en        = 1'b0;
        sfr_rd_addr      = 8'h00;
        sfr_write_en     = 1'b0;
        sfr_write_bit_en = 1'b0;
        ack0             = 1'b0;
        ack1             = 1'b0;
        busy             = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = is_rmw(op_t'(sel_op)) ? ST_READ : ST_WRITE;
                end
            end
            ST_READ: begin
                sfr_rd_en   = 1'b1;
                sfr_rd_addr = is_bit_op(op_t'(op_q)) ? {addr_q[7:3], 3'b000}
                                                     : addr_q;
                state_d     = (RD_LATENCY == 2) ? ST_WAIT : ST_MODIFY;
            end
            ST_WAIT: begin
                state_d = ST_MODIFY;
            end
            ST_MODIFY: begin
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                sfr_write_en     = 1'b1;
                sfr_write_bit_en = is_bit_op(op_t'(op_q));
                ack0             = ~grant_q;
                ack1             = grant_q;
                state_d          = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request latching and the write payload. Direct ops know their payload
    // at grant time; RMW ops fill it in from the ALU in MODIFY. Bit writes
    // leave sfr_data untouched and byte writes leave sfr_bit untouched so
    // both hold their last values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            op_q         <= 3'd0;
            addr_q       <= 8'h00;
            data_q       <= 8'h00;
            bit_q        <= 1'b0;
            sfr_addr_q   <= 8'h00;
            sfr_data_q   <= 8'h00;
            sfr_bit_q    <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && any_req) begin
                grant_q      <= grant_sel;
                last_grant_q <= grant_sel;
                op_q         <= sel_op;
                addr_q       <= sel_addr;
                data_q       <= sel_data;
                bit_q        <= sel_bit;
                if (!is_rmw(op_t'(sel_op))) begin
                    sfr_addr_q <= sel_addr;
                    if (is_bit_op(op_t'(sel_op))) begin
                        sfr_bit_q <= (op_t'(sel_op) == OP_MOVB) ? sel_bit
                                   : (op_t'(sel_op) == OP_SETB);
                    end else begin
                        sfr_data_q <= sel_data;
                    end
                end
            end
            if (state_q == ST_MODIFY) begin
                sfr_addr_q <= addr_q;
                if (is_bit_op(op_t'(op_q))) begin
                    sfr_bit_q <= alu_bit;
                end else begin
                    sfr_data_q <= alu_byte;
                end
            end
        end
    end

    assign sfr_addr = sfr_addr_q;
    assign sfr_data = sfr_data_q;
    assign sfr_bit  = sfr_bit_q;

endmodule
